// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: data word and memory-viewer FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    SHOW
  } viewstate_t;

  // Width of the word index held in addr[15:2].
  localparam int unsigned VIEW_IDX_W = 14;

  // Build a word-aligned address in the low 64 KiB from a word index.
  function automatic word_t view_addr(input logic [VIEW_IDX_W-1:0] idx);
    return {16'h0000, idx, 2'b00};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton debouncer: 2-flop synchronizer plus stability counter.
// Emits a single-cycle press pulse once the key has been stably low;
// it re-arms only after the key has been stably high again.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic CLK,
  input  logic nRST,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronize the raw key into the CLK domain; released (high) at reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples;
  // any return to the accepted level restarts the count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_view_ctrl.sv
// Board-side memory viewer: after CPU halt, takes over the memory port,
// walks word addresses from switches, keys or auto-scan, and latches
// the read data for display.
module mem_view_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned READ_WAIT       = 2,
  parameter int unsigned SCAN_CYCLES     = 25000000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  word_t       load,
  input  logic [15:0] sw_base,
  input  logic        sw_auto,
  input  logic        key_next_n,
  input  logic        key_prev_n,
  input  logic        key_base_n,
  output word_t       addr,
  output logic        ren,
  output logic        tbctrl,
  output word_t       word,
  output logic        word_valid,
  output logic        busy
);

  localparam int unsigned RCW = (READ_WAIT < 2) ? 1 : $clog2(READ_WAIT + 1);
  localparam int unsigned SCW = (SCAN_CYCLES < 2) ? 1 : $clog2(SCAN_CYCLES + 1);

  viewstate_t              state;
  logic [VIEW_IDX_W-1:0]   addr_idx;
  logic [RCW-1:0]          settle_cnt;
  logic [SCW-1:0]          dwell_cnt;

  logic                    press_next;
  logic                    press_prev;
  logic                    press_base;

  logic                    ev_accept;
  logic [VIEW_IDX_W-1:0]   ev_idx;

  logic                    unused_sw_lsbs;
  assign unused_sw_lsbs = ^sw_base[1:0];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
    .CLK   (CLK),
    .nRST  (nRST),
    .key_n (key_next_n),
    .press (press_next)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_prev (
    .CLK   (CLK),
    .nRST  (nRST),
    .key_n (key_prev_n),
    .press (press_prev)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_base (
    .CLK   (CLK),
    .nRST  (nRST),
    .key_n (key_base_n),
    .press (press_base)
  );

  assign addr = view_addr(addr_idx);

  // Resolve SHOW-state events: base > next/prev (simultaneous cancels) > auto-scan.
  always_comb begin
    ev_accept = 1'b0;
    ev_idx    = addr_idx;
    if (press_base) begin
      ev_accept = 1'b1;
      ev_idx    = sw_base[15:2];
    end else if (press_next && !press_prev) begin
      ev_accept = 1'b1;
      ev_idx    = addr_idx + 1'b1;
    end else if (press_prev && !press_next) begin
      ev_accept = 1'b1;
      ev_idx    = addr_idx - 1'b1;
    end else if (sw_auto && (dwell_cnt == SCW'(SCAN_CYCLES - 1))) begin
      ev_accept = 1'b1;
      ev_idx    = addr_idx + 1'b1;
    end
  end

  // Viewer FSM with registered port-control, address and display outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      addr_idx   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      ren        <= 1'b0;
      tbctrl     <= 1'b0;
      busy       <= 1'b0;
      settle_cnt <= '0;
      dwell_cnt  <= '0;
    end else begin
      if (!sw_auto) begin
        dwell_cnt <= '0;
      end
      if (!halt) begin
        // Release the port; word and address are kept for the display.
        state      <= IDLE;
        ren        <= 1'b0;
        tbctrl     <= 1'b0;
        word_valid <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            addr_idx   <= sw_base[15:2];
            settle_cnt <= '0;
            ren        <= 1'b1;
            tbctrl     <= 1'b1;
            busy       <= 1'b1;
            word_valid <= 1'b0;
            state      <= SETTLE;
          end
          SETTLE: begin
            if (settle_cnt == RCW'(READ_WAIT - 1)) begin
              state <= CAPTURE;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          CAPTURE: begin
            word       <= load;
            word_valid <= 1'b1;
            busy       <= 1'b0;
            dwell_cnt  <= '0;
            state      <= SHOW;
          end
          SHOW: begin
            if (ev_accept) begin
              addr_idx   <= ev_idx;
              word_valid <= 1'b0;
              busy       <= 1'b1;
              settle_cnt <= '0;
              dwell_cnt  <= '0;
              state      <= SETTLE;
            end else if (sw_auto) begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_view_ctrl.sv
// Directed self-checking bench for mem_view_ctrl with short timing parameters.
module tb_mem_view_ctrl;

  logic        CLK;
  logic        nRST;
  logic        halt;
  logic [31:0] load;
  logic [15:0] sw_base;
  logic        sw_auto;
  logic        key_next_n;
  logic        key_prev_n;
  logic        key_base_n;
  logic [31:0] addr;
  logic        ren;
  logic        tbctrl;
  logic [31:0] word;
  logic        word_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_view_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .READ_WAIT      (2),
    .SCAN_CYCLES    (8)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .halt       (halt),
    .load       (load),
    .sw_base    (sw_base),
    .sw_auto    (sw_auto),
    .key_next_n (key_next_n),
    .key_prev_n (key_prev_n),
    .key_base_n (key_base_n),
    .addr       (addr),
    .ren        (ren),
    .tbctrl     (tbctrl),
    .word       (word),
    .word_valid (word_valid),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: data follows the address one cycle later.
  always @(posedge CLK) load <= addr ^ 32'hA5A5_0000;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Hold the selected keys low long enough for one pulse, then release and re-arm.
  task automatic press_keys(input logic nxt, input logic prv, input logic bas);
    key_next_n = ~nxt;
    key_prev_n = ~prv;
    key_base_n = ~bas;
    tick(8);
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    key_base_n = 1'b1;
    tick(8);
  endtask

  task automatic test_reset;
    nRST = 1'b0; halt = 1'b0; sw_base = 16'h0013; sw_auto = 1'b0;
    key_next_n = 1'b1; key_prev_n = 1'b1; key_base_n = 1'b1; load = '0;
    tick(3);
    checks++; if ({addr, word, ren, tbctrl, word_valid, busy} !== 68'h0) begin
      errors++; $display("FAIL reset_outputs: addr=%h word=%h ren=%b tbctrl=%b wv=%b busy=%b exp all 0", addr, word, ren, tbctrl, word_valid, busy);
    end
    nRST = 1'b1;
    tick(2);
    checks++; if (ren !== 1'b0) begin errors++; $display("FAIL idle_ren: got %b exp 0", ren); end
  endtask

  task automatic test_halt_start;
    halt = 1'b1;
    tick(1);
    checks++; if (addr !== 32'h0000_0010) begin errors++; $display("FAIL halt_addr: got %h exp 00000010", addr); end
    checks++; if ({ren, tbctrl, busy, word_valid} !== 4'b1110) begin
      errors++; $display("FAIL halt_ctrl: ren/tbctrl/busy/wv got %b exp 1110", {ren, tbctrl, busy, word_valid});
    end
    tick(2);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL halt_early_valid: got %b exp 0", word_valid); end
    tick(1);
    checks++; if (word !== 32'hA5A5_0010) begin errors++; $display("FAIL halt_word: got %h exp a5a50010", word); end
    checks++; if ({word_valid, busy} !== 2'b10) begin errors++; $display("FAIL halt_valid: wv/busy got %b exp 10", {word_valid, busy}); end
  endtask

  task automatic test_debounce;
    tick(2);
    key_next_n = 1'b0;
    tick(6);
    checks++; if (addr !== 32'h0000_0010) begin errors++; $display("FAIL deb_early: got %h exp 00000010", addr); end
    tick(1);
    checks++; if (addr !== 32'h0000_0014) begin errors++; $display("FAIL deb_step: got %h exp 00000014", addr); end
    tick(13);
    key_next_n = 1'b1;
    checks++; if (addr !== 32'h0000_0014) begin errors++; $display("FAIL deb_held_once: got %h exp 00000014", addr); end
    tick(10);
    checks++; if ({word, word_valid} !== {32'hA5A5_0014, 1'b1}) begin
      errors++; $display("FAIL deb_word: got %h/%b exp a5a50014/1", word, word_valid);
    end
    key_next_n = 1'b0;
    tick(3);
    key_next_n = 1'b1;
    tick(15);
    checks++; if (addr !== 32'h0000_0014) begin errors++; $display("FAIL deb_glitch: got %h exp 00000014", addr); end
  endtask

  task automatic test_wrap;
    sw_base = 16'hFFFC;
    press_keys(1'b0, 1'b0, 1'b1);
    checks++; if ({addr, word} !== {32'h0000_FFFC, 32'hA5A5_FFFC}) begin
      errors++; $display("FAIL wrap_base: addr=%h word=%h exp 0000fffc a5a5fffc", addr, word);
    end
    press_keys(1'b1, 1'b0, 1'b0);
    checks++; if ({addr, word} !== {32'h0000_0000, 32'hA5A5_0000}) begin
      errors++; $display("FAIL wrap_next: addr=%h word=%h exp 00000000 a5a50000", addr, word);
    end
    press_keys(1'b0, 1'b1, 1'b0);
    checks++; if (addr !== 32'h0000_FFFC) begin errors++; $display("FAIL wrap_prev: got %h exp 0000fffc", addr); end
  endtask

  task automatic test_priority;
    press_keys(1'b1, 1'b1, 1'b0);
    checks++; if ({addr, word_valid} !== {32'h0000_FFFC, 1'b1}) begin
      errors++; $display("FAIL prio_cancel: got %h/%b exp 0000fffc/1", addr, word_valid);
    end
    sw_base = 16'h0101;
    press_keys(1'b1, 1'b0, 1'b1);
    checks++; if ({addr, word} !== {32'h0000_0100, 32'hA5A5_0100}) begin
      errors++; $display("FAIL prio_base: addr=%h word=%h exp 00000100 a5a50100", addr, word);
    end
  endtask

  task automatic test_auto_scan;
    sw_auto = 1'b1;
    tick(7);
    checks++; if (addr !== 32'h0000_0100) begin errors++; $display("FAIL auto_dwell: got %h exp 00000100", addr); end
    tick(1);
    checks++; if ({addr, busy} !== {32'h0000_0104, 1'b1}) begin
      errors++; $display("FAIL auto_step1: got %h/%b exp 00000104/1", addr, busy);
    end
    tick(5);
    key_next_n = 1'b0;
    tick(6);
    checks++; if (addr !== 32'h0000_0108) begin errors++; $display("FAIL auto_step2: got %h exp 00000108", addr); end
    tick(2);
    key_next_n = 1'b1;
    tick(8);
    checks++; if (addr !== 32'h0000_0108) begin errors++; $display("FAIL auto_drop_key: got %h exp 00000108", addr); end
    tick(1);
    checks++; if (addr !== 32'h0000_010C) begin errors++; $display("FAIL auto_step3: got %h exp 0000010c", addr); end
    sw_auto = 1'b0;
    tick(10);
  endtask

  task automatic test_halt_drop_and_reset;
    key_next_n = 1'b0;
    tick(7);
    checks++; if ({addr, busy} !== {32'h0000_0110, 1'b1}) begin
      errors++; $display("FAIL drop_settle: got %h/%b exp 00000110/1", addr, busy);
    end
    halt = 1'b0;
    tick(1);
    checks++; if ({ren, tbctrl, word_valid, busy} !== 4'b0000) begin
      errors++; $display("FAIL drop_ctrl: ren/tbctrl/wv/busy got %b exp 0000", {ren, tbctrl, word_valid, busy});
    end
    checks++; if ({word, addr} !== {32'hA5A5_010C, 32'h0000_0110}) begin
      errors++; $display("FAIL drop_hold: word=%h addr=%h exp a5a5010c 00000110", word, addr);
    end
    key_next_n = 1'b1;
    tick(10);
    halt = 1'b1;
    tick(4);
    checks++; if ({word, word_valid} !== {32'hA5A5_0100, 1'b1}) begin
      errors++; $display("FAIL rehalt_word: got %h/%b exp a5a50100/1", word, word_valid);
    end
    tick(2);
    nRST = 1'b0;
    #1;
    checks++; if ({addr, word, ren, tbctrl, word_valid, busy} !== 68'h0) begin
      errors++; $display("FAIL async_reset: addr=%h word=%h ren=%b tbctrl=%b wv=%b busy=%b exp all 0", addr, word, ren, tbctrl, word_valid, busy);
    end
    tick(2);
    nRST = 1'b1;
  endtask

  initial begin
    test_reset();
    test_halt_start();
    test_debounce();
    test_wrap();
    test_priority();
    test_auto_scan();
    test_halt_drop_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_view_ctrl.md
# mem_view_ctrl

- Board-side memory viewer controller. It sits between the board pushbuttons/switches and the system's testbench memory port, upstream of the hex-display decode.
- After the CPU halts, it takes control of the memory port (tbCTRL/REN) and drives word-aligned addresses from a switch base, debounced step keys, or auto-scan.
- It waits a fixed read latency, then latches the returned load word for display.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250000: cycles a synchronized key must stay stable before a press or release is accepted.
- READ_WAIT, 2: cycles the address is held stable before `load` is sampled.
- SCAN_CYCLES, 25000000: display dwell per word in auto-scan mode.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  reset; one clock, asynchronous assert, active-low.
- halt  in  1  CPU halted.
- load  in  32  memory read data.
- sw_base  in  16  base byte address from switches.
- sw_auto  in  1  level; 1 = auto-scan.
- key_next_n  in  1  raw pushbutton, active-low; step +4.
- key_prev_n  in  1  raw pushbutton, active-low; step −4.
- key_base_n  in  1  raw pushbutton, active-low; reload base.
- addr  out  32  memory address.
- ren  out  1  memory read enable.
- tbctrl  out  1  testbench control of the memory port.
- word  out  32  latched display word.
- word_valid  out  1  `word` matches current `addr`.
- busy  out  1  high in SETTLE/CAPTURE.

## Operation
Reset values:
- All outputs 0; state IDLE.
- Debouncers report released.

Address rules:
- addr[31:16] = 0 and addr[1:0] = 0 always.
- Steps are modulo 2^14 on addr[15:2]: 0xFFFC + 4 → 0x0000; 0x0000 − 4 → 0xFFFC.
- Base load takes addr = {16'b0, sw_base[15:2], 2'b00}.

States:
- IDLE: ren = tbctrl = 0, word_valid = 0. On halt = 1: base load, go to SETTLE.
- SETTLE: ren = tbctrl = 1. Counts READ_WAIT cycles, then goes to CAPTURE.
- CAPTURE: one cycle. word ← load, word_valid ← 1, go to SHOW.
- SHOW: ren = tbctrl = 1. Waits for an event.

Events in SHOW (priority base > next > prev):
- base press → base load.
- next press and prev press in the same cycle → both ignored.
- next press → +4.
- prev press → −4.
- sw_auto = 1 and dwell counter reaches SCAN_CYCLES → +4.
- Any accepted event: word_valid ← 0, go to SETTLE.

Event filtering:
- Key pulses arriving while busy = 1 are dropped, not queued.
- Auto-scan dwell counter clears on every entry to SHOW and whenever sw_auto = 0.

halt deassert:
- halt = 0 in any state → IDLE next cycle.
- word_valid clears; word and addr hold their values.

Debounce (per key):
- 2-flop synchronizer, then a stability counter.
- Emits a one-cycle press pulse when the synchronized level has been low for DEBOUNCE_CYCLES consecutive cycles.
- Re-arms only after a stable high for DEBOUNCE_CYCLES.
- A held key yields exactly one pulse.
- Any level change restarts the counter.

## Timing
- Key-to-pulse latency: 2 + DEBOUNCE_CYCLES cycles.
- Pulse to addr update: 1 cycle, entering SETTLE.
- addr update to word update: READ_WAIT + 1 cycles (READ_WAIT in SETTLE, then CAPTURE registers `load`).
- halt rise → first valid word: 1 + READ_WAIT + 1 cycles.
- `load` is sampled only in CAPTURE; it is a don't-care elsewhere.
- All outputs are registered; none are combinational from inputs.
- Reset assertion mid-SETTLE/SHOW forces the reset values immediately (asynchronous).

## Structure
- cpu_types_pkg gains `viewstate_t` (IDLE, SETTLE, CAPTURE, SHOW).
- `word` and `addr` use the existing `word_t`.
- Sub-module `key_debounce` (param DEBOUNCE_CYCLES; ports CLK, nRST, key_n → press), instantiated three times.
- Top holds the FSM, settle counter, dwell counter and address register.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, READ_WAIT=2, SCAN_CYCLES=8; memory model returns load = addr ^ 0xA5A5_0000 one cycle after addr changes.

1. Reset, sw_base=0x0013, raise halt → addr=0x0010 next cycle; ren=tbctrl=1; word=0xA5A5_0010 with word_valid=1 four cycles after halt.
2. In SHOW, hold key_next_n low 20 cycles → exactly one step to 0x0014, seen 7 cycles after the falling edge. A 3-cycle glitch low gives no step.
3. addr=0xFFFC, press next → 0x0000; press prev → 0xFFFC.
4. next and prev pulses in the same cycle → no change. base + next pulses in the same cycle → base load.
5. sw_auto=1 → addr advances +4 every 8 + 3 cycles. A key pulse during SETTLE is dropped (busy=1).
6. Drop halt during SETTLE → IDLE next cycle; ren=tbctrl=word_valid=0; word unchanged. Assert nRST in SHOW → all outputs 0 immediately.
